// File: rtl/bht_table_if.sv
// Branch-unit write port and fetch-side lookup port of the branch history table.
interface bht_table_if #(
  parameter int BHTBTB_INDEX_WIDTH = 9
);
  logic                          bjusb_bht_write_enable;
  logic [BHTBTB_INDEX_WIDTH-1:0] bjusb_bht_write_index;
  logic [1:0]                    bjusb_bht_write_counter_select;
  logic                          bjusb_bht_write_inc;
  logic                          bjusb_bht_write_dec;
  logic                          bjusb_bht_valid_in;
  logic                          bpu_read_valid;
  logic [BHTBTB_INDEX_WIDTH-1:0] bpu_read_index;
  logic                          bpu_read_ready;
  logic                          bpu_read_resp_valid;
  logic [7:0]                    bpu_read_counters;
  logic [3:0]                    bpu_read_valids;
  logic [3:0]                    bpu_read_taken;

  modport master (
    output bjusb_bht_write_enable, bjusb_bht_write_index, bjusb_bht_write_counter_select,
    output bjusb_bht_write_inc, bjusb_bht_write_dec, bjusb_bht_valid_in,
    output bpu_read_valid, bpu_read_index,
    input  bpu_read_ready, bpu_read_resp_valid, bpu_read_counters, bpu_read_valids, bpu_read_taken
  );

  modport slave (
    input  bjusb_bht_write_enable, bjusb_bht_write_index, bjusb_bht_write_counter_select,
    input  bjusb_bht_write_inc, bjusb_bht_write_dec, bjusb_bht_valid_in,
    input  bpu_read_valid, bpu_read_index,
    output bpu_read_ready, bpu_read_resp_valid, bpu_read_counters, bpu_read_valids, bpu_read_taken
  );
endinterface

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters with valid bits, one-stage
// read-modify-write update pipeline, registered lookups, and a post-reset init sweep.
module bht_table #(
  parameter int         BHTBTB_INDEX_WIDTH = 9,
  parameter logic [1:0] INIT_COUNTER       = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  bht_table_if.slave  bus,
  output logic        init_done,
  output logic [15:0] bht_drop_cnt
);
  localparam int SETS = 2 ** BHTBTB_INDEX_WIDTH;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic inc, input logic dec);
    logic [1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != 2'b11)) begin
      res = cnt + 2'b01;
    end else if (dec && !inc && (cnt != 2'b00)) begin
      res = cnt - 2'b01;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_t                        state_r, state_nxt_s;
  logic [BHTBTB_INDEX_WIDTH-1:0] init_ptr_r;
  logic                          run_s, init_s;
  logic [7:0]                    cnt_mem_r [SETS];
  logic [3:0]                    vld_mem_r [SETS];
  logic                          stage_valid_r;
  logic [BHTBTB_INDEX_WIDTH-1:0] stage_index_r;
  logic [1:0]                    stage_sel_r;
  logic                          stage_inc_r, stage_dec_r;
  logic [7:0]                    cur_cnt_s, commit_cnt_s, rd_cnt_s;
  logic [3:0]                    cur_vld_s, commit_vld_s, rd_vld_s;
  logic                          wr_req_s, wr_accept_s, wr_drop_s, rd_accept_s, rd_hit_s;
  logic                          resp_valid_r, init_done_r;
  logic [7:0]                    resp_cnt_r;
  logic [3:0]                    resp_vld_r, resp_taken_r;
  logic [15:0]                   drop_cnt_r;

  // FSM state register and init sweep pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_INIT;
      init_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        init_ptr_r <= init_ptr_r + {{(BHTBTB_INDEX_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // FSM next state: leave INIT after the last set is written
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_ptr_r == {BHTBTB_INDEX_WIDTH{1'b1}}) state_nxt_s = ST_RUN;
        else                                           state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    run_s  = 1'b0;
    init_s = 1'b0;
    case (state_r)
      ST_INIT: init_s = 1'b1;
      ST_RUN:  run_s  = 1'b1;
      default: init_s = 1'b1;
    endcase
  end

  assign wr_req_s    = bus.bjusb_bht_write_enable && bus.bjusb_bht_valid_in;
  assign wr_accept_s = wr_req_s && run_s;
  assign wr_drop_s   = wr_req_s && init_s;
  assign rd_accept_s = bus.bpu_read_valid && run_s;

  // Commit datapath: modify the selected counter of the staged set
  always_comb begin
    cur_cnt_s    = cnt_mem_r[stage_index_r];
    cur_vld_s    = vld_mem_r[stage_index_r];
    commit_cnt_s = cur_cnt_s;
    commit_vld_s = cur_vld_s;
    case (stage_sel_r)
      2'd0: begin commit_cnt_s[1:0] = sat_update(cur_cnt_s[1:0], stage_inc_r, stage_dec_r); commit_vld_s[0] = 1'b1; end
      2'd1: begin commit_cnt_s[3:2] = sat_update(cur_cnt_s[3:2], stage_inc_r, stage_dec_r); commit_vld_s[1] = 1'b1; end
      2'd2: begin commit_cnt_s[5:4] = sat_update(cur_cnt_s[5:4], stage_inc_r, stage_dec_r); commit_vld_s[2] = 1'b1; end
      2'd3: begin commit_cnt_s[7:6] = sat_update(cur_cnt_s[7:6], stage_inc_r, stage_dec_r); commit_vld_s[3] = 1'b1; end
      default: begin commit_cnt_s = cur_cnt_s; commit_vld_s = cur_vld_s; end
    endcase
  end

  // Lookup data with bypass of a same-cycle commit to the same set
  always_comb begin
    rd_hit_s = stage_valid_r && (stage_index_r == bus.bpu_read_index);
    if (rd_hit_s) begin
      rd_cnt_s = commit_cnt_s;
      rd_vld_s = commit_vld_s;
    end else begin
      rd_cnt_s = cnt_mem_r[bus.bpu_read_index];
      rd_vld_s = vld_mem_r[bus.bpu_read_index];
    end
  end

  // Array write: init sweep or commit; a reset cycle discards the pending commit
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_r == ST_INIT) begin
        cnt_mem_r[init_ptr_r] <= {4{INIT_COUNTER}};
        vld_mem_r[init_ptr_r] <= 4'h0;
      end else if (stage_valid_r) begin
        cnt_mem_r[stage_index_r] <= commit_cnt_s;
        vld_mem_r[stage_index_r] <= commit_vld_s;
      end
    end
  end

  // Write stage, lookup response and drop counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid_r <= 1'b0;
      stage_index_r <= '0;
      stage_sel_r   <= 2'b00;
      stage_inc_r   <= 1'b0;
      stage_dec_r   <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_cnt_r    <= 8'h00;
      resp_vld_r    <= 4'h0;
      resp_taken_r  <= 4'h0;
      drop_cnt_r    <= 16'h0000;
      init_done_r   <= 1'b0;
    end else begin
      stage_valid_r <= wr_accept_s;
      if (wr_accept_s) begin
        stage_index_r <= bus.bjusb_bht_write_index;
        stage_sel_r   <= bus.bjusb_bht_write_counter_select;
        stage_inc_r   <= bus.bjusb_bht_write_inc;
        stage_dec_r   <= bus.bjusb_bht_write_dec;
      end
      resp_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        resp_cnt_r   <= rd_cnt_s;
        resp_vld_r   <= rd_vld_s;
        resp_taken_r <= {rd_cnt_s[7], rd_cnt_s[5], rd_cnt_s[3], rd_cnt_s[1]};
      end
      if (wr_drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign bus.bpu_read_ready      = run_s;
  assign init_done               = init_done_r;
  assign bus.bpu_read_resp_valid = resp_valid_r;
  assign bus.bpu_read_counters   = resp_cnt_r;
  assign bus.bpu_read_valids     = resp_vld_r;
  assign bus.bpu_read_taken      = resp_taken_r;
  assign bht_drop_cnt            = drop_cnt_r;
endmodule

// File: tb/tb_bht_table.sv
// Directed self-checking bench for bht_table: init sweep, saturating updates,
// write/read ordering with bypass, INIT drops and mid-run reset.
module tb_bht_table;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        init_done;
  logic [15:0] bht_drop_cnt;
  int          checks = 0;
  int          failures = 0;

  bht_table_if #(.BHTBTB_INDEX_WIDTH(9)) bif ();

  bht_table #(.BHTBTB_INDEX_WIDTH(9), .INIT_COUNTER(2'b01)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bif),
    .init_done    (init_done),
    .bht_drop_cnt (bht_drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bif.bjusb_bht_write_enable         = 1'b0;
    bif.bjusb_bht_valid_in             = 1'b0;
    bif.bjusb_bht_write_index          = 9'd0;
    bif.bjusb_bht_write_counter_select = 2'd0;
    bif.bjusb_bht_write_inc            = 1'b0;
    bif.bjusb_bht_write_dec            = 1'b0;
    bif.bpu_read_valid                 = 1'b0;
    bif.bpu_read_index                 = 9'd0;
  endtask

  task automatic set_write(input logic [8:0] idx, input logic [1:0] sel, input logic inc, input logic dec);
    bif.bjusb_bht_write_enable         = 1'b1;
    bif.bjusb_bht_valid_in             = 1'b1;
    bif.bjusb_bht_write_index          = idx;
    bif.bjusb_bht_write_counter_select = sel;
    bif.bjusb_bht_write_inc            = inc;
    bif.bjusb_bht_write_dec            = dec;
  endtask

  task automatic set_read(input logic [8:0] idx);
    bif.bpu_read_valid = 1'b1;
    bif.bpu_read_index = idx;
  endtask

  // count cycles until init_done, bounded
  task automatic wait_init(input string name, input bit drive_drops);
    int cyc = 0;
    bit early_resp = 1'b0;
    while (!init_done && cyc < 600) begin
      if (drive_drops && cyc < 3) set_write(9'(cyc + 20), 2'd1, 1'b1, 1'b0);
      else bif.bjusb_bht_write_enable = 1'b0;
      set_read(9'd5);
      step();
      cyc++;
      if (bif.bpu_read_resp_valid && !init_done) early_resp = 1'b1;
      if (bif.bpu_read_ready !== init_done) early_resp = 1'b1;
    end
    idle_inputs();
    checks++;
    if (cyc !== 512) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=512", name, cyc);
    end
    checks++;
    if (early_resp !== 1'b0) begin
      failures++;
      $display("FAIL %s_no_resp_in_init got=%0b exp=0", name, early_resp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    set_read(9'd1);
    set_write(9'd1, 2'd0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if ({bif.bpu_read_ready, init_done, bif.bpu_read_resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bif.bpu_read_ready, init_done, bif.bpu_read_resp_valid});
    end
    checks++;
    if ({bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken, bht_drop_cnt} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0",
               {bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken, bht_drop_cnt});
    end
  endtask

  task automatic test_init_drops();
    logic [8:0] idxs [4];
    idxs[0] = 9'd5; idxs[1] = 9'd0; idxs[2] = 9'd511; idxs[3] = 9'd21;
    wait_init("init", 1'b1);
    checks++;
    if (bht_drop_cnt !== 16'd3) begin
      failures++;
      $display("FAIL drop_cnt got=%0d exp=3", bht_drop_cnt);
    end
    foreach (idxs[i]) begin
      set_read(idxs[i]);
      step();
      idle_inputs();
      checks++;
      if ({bif.bpu_read_resp_valid, bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken} !== {1'b1, 8'h55, 4'h0, 4'h0}) begin
        failures++;
        $display("FAIL init_read_%0d got=%b/%h/%h/%h exp=1/55/0/0", idxs[i], bif.bpu_read_resp_valid,
                 bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken);
      end
    end
    step();
    checks++;
    if ({bif.bpu_read_resp_valid, bif.bpu_read_counters} !== {1'b0, 8'h55}) begin
      failures++;
      $display("FAIL resp_hold got=%b/%h exp=0/55", bif.bpu_read_resp_valid, bif.bpu_read_counters);
    end
  endtask

  task automatic test_sat_inc();
    logic [1:0] exp_c [4];
    exp_c[0] = 2'b10; exp_c[1] = 2'b11; exp_c[2] = 2'b11; exp_c[3] = 2'b11;
    set_write(9'd3, 2'd2, 1'b1, 1'b0);
    step();
    // each read sees the commit of the previous write through the bypass
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bif.bjusb_bht_write_enable = 1'b0;
      set_read(9'd3);
      step();
      checks++;
      if (bif.bpu_read_counters[5:4] !== exp_c[i]) begin
        failures++;
        $display("FAIL inc_step%0d got=%b exp=%b", i, bif.bpu_read_counters[5:4], exp_c[i]);
      end
    end
    idle_inputs();
    step();
    set_read(9'd3);
    step();
    idle_inputs();
    checks++;
    if ({bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken} !== {8'h75, 4'b0100, 4'b0100}) begin
      failures++;
      $display("FAIL inc_final got=%h/%b/%b exp=75/0100/0100", bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken);
    end
  endtask

  task automatic test_sat_dec();
    set_write(9'd7, 2'd0, 1'b0, 1'b1);
    step();
    step();
    idle_inputs();
    step();
    set_read(9'd7);
    step();
    idle_inputs();
    checks++;
    if ({bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken} !== {8'h54, 4'b0001, 4'b0000}) begin
      failures++;
      $display("FAIL dec_sat got=%h/%b/%b exp=54/0001/0000", bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken);
    end
    set_write(9'd7, 2'd1, 1'b1, 1'b1);
    step();
    idle_inputs();
    step();
    set_read(9'd7);
    step();
    idle_inputs();
    checks++;
    if ({bif.bpu_read_counters, bif.bpu_read_valids} !== {8'h54, 4'b0011}) begin
      failures++;
      $display("FAIL inc_dec_hold got=%h/%b exp=54/0011", bif.bpu_read_counters, bif.bpu_read_valids);
    end
  endtask

  task automatic test_back_to_back();
    set_write(9'd9, 2'd1, 1'b1, 1'b0);
    set_read(9'd9);
    step();
    bif.bjusb_bht_write_enable = 1'b0;
    checks++;
    if ({bif.bpu_read_resp_valid, bif.bpu_read_counters} !== {1'b1, 8'h55}) begin
      failures++;
      $display("FAIL order_same_cycle got=%b/%h exp=1/55", bif.bpu_read_resp_valid, bif.bpu_read_counters);
    end
    step();
    idle_inputs();
    checks++;
    if ({bif.bpu_read_resp_valid, bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken} !== {1'b1, 8'h59, 4'b0010, 4'b0010}) begin
      failures++;
      $display("FAIL order_bypass got=%b/%h/%b/%b exp=1/59/0010/0010", bif.bpu_read_resp_valid,
               bif.bpu_read_counters, bif.bpu_read_valids, bif.bpu_read_taken);
    end
  endtask

  task automatic test_mid_reset();
    set_write(9'd3, 2'd0, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    set_read(9'd3);
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if ({bif.bpu_read_resp_valid, init_done, bif.bpu_read_ready, bht_drop_cnt, bif.bpu_read_counters} !== {3'b000, 16'h0, 8'h00}) begin
      failures++;
      $display("FAIL midreset_state got=%b/%b/%b/%0d/%h exp=0/0/0/0/00", bif.bpu_read_resp_valid,
               init_done, bif.bpu_read_ready, bht_drop_cnt, bif.bpu_read_counters);
    end
    wait_init("midreset", 1'b0);
    set_read(9'd3);
    step();
    idle_inputs();
    checks++;
    if ({bif.bpu_read_counters, bif.bpu_read_valids} !== {8'h55, 4'h0}) begin
      failures++;
      $display("FAIL midreset_read got=%h/%h exp=55/0", bif.bpu_read_counters, bif.bpu_read_valids);
    end
  endtask

  initial begin
    idle_inputs();
    step();
    test_reset();
    test_init_drops();
    test_sat_inc();
    test_sat_dec();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
